// File: rtl/parking_gate_controller_if.sv
// rtl/parking_gate_controller_if.sv - sensor pulses in, occupancy status and gate drives out
interface parking_gate_controller_if #(
    parameter int CNT_W = 5
);
    logic             entry_pulse;
    logic             exit_pulse;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] free_spaces;
    logic             full;
    logic             empty;
    logic             gate_in_open;
    logic             gate_out_open;
    logic             reject_pulse;
    logic             underflow_pulse;

    modport slave (
        input  entry_pulse, exit_pulse,
        output occupancy, free_spaces, full, empty,
               gate_in_open, gate_out_open, reject_pulse, underflow_pulse
    );

    modport master (
        output entry_pulse, exit_pulse,
        input  occupancy, free_spaces, full, empty,
               gate_in_open, gate_out_open, reject_pulse, underflow_pulse
    );
endinterface

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - lot occupancy tracking and timed entry/exit barrier sequencing
module parking_gate_controller #(
    parameter int CAPACITY    = 16,
    parameter int CNT_W       = 5,
    parameter int GATE_CYCLES = 100,
    parameter int TMR_W       = 16
) (
    input logic                  clk,
    input logic                  reset,
    parking_gate_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IN_OPEN, OUT_OPEN} state_t;

    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

    state_t           state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             pend_in, pend_in_n;
    logic             pend_out, pend_out_n;
    logic [CNT_W-1:0] occ, occ_n;
    logic [CNT_W-1:0] free_q;
    logic             full_q, empty_q;
    logic             gate_in_q, gate_out_q;
    logic             reject_q, reject_n;
    logic             underflow_q, underflow_n;
    logic             in_req, out_req;

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        pend_in_n   = pend_in;
        pend_out_n  = pend_out;
        occ_n       = occ;
        reject_n    = 1'b0;
        underflow_n = 1'b0;
        in_req      = bus.entry_pulse | pend_in;
        out_req     = bus.exit_pulse | pend_out;

        case (state)
            IDLE: begin
                // Exit wins a tie; a simultaneous entry request is parked in pend_in.
                if (out_req) begin
                    pend_out_n = 1'b0;
                    if (occ == '0) begin
                        underflow_n = 1'b1;
                    end else begin
                        state_n = OUT_OPEN;
                        occ_n   = occ - 1'b1;
                        timer_n = TMR_LOAD;
                    end
                    if (in_req) pend_in_n = 1'b1;
                end else if (in_req) begin
                    pend_in_n = 1'b0;
                    if (occ == CAP) begin
                        reject_n = 1'b1;
                    end else begin
                        state_n = IN_OPEN;
                        occ_n   = occ + 1'b1;
                        timer_n = TMR_LOAD;
                    end
                end
            end
            default: begin
                if (bus.entry_pulse) pend_in_n  = 1'b1;
                if (bus.exit_pulse)  pend_out_n = 1'b1;
                if (timer == '0) state_n = IDLE;
                else             timer_n = timer - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            pend_in     <= 1'b0;
            pend_out    <= 1'b0;
            occ         <= '0;
            free_q      <= CAP;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            gate_in_q   <= 1'b0;
            gate_out_q  <= 1'b0;
            reject_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            pend_in     <= pend_in_n;
            pend_out    <= pend_out_n;
            occ         <= occ_n;
            free_q      <= CAP - occ_n;
            full_q      <= (occ_n == CAP);
            empty_q     <= (occ_n == '0);
            gate_in_q   <= (state_n == IN_OPEN);
            gate_out_q  <= (state_n == OUT_OPEN);
            reject_q    <= reject_n;
            underflow_q <= underflow_n;
        end
    end

    assign bus.occupancy       = occ;
    assign bus.free_spaces     = free_q;
    assign bus.full            = full_q;
    assign bus.empty           = empty_q;
    assign bus.gate_in_open    = gate_in_q;
    assign bus.gate_out_open   = gate_out_q;
    assign bus.reject_pulse    = reject_q;
    assign bus.underflow_pulse = underflow_q;
endmodule
